// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder (with full_adder bit-slice)
// Desc     : Bit-serial WIDTH-bit adder, LSB-first, one full-adder slice and a
//            carry flip-flop. Define SERIAL_ADDER_OVF_EN to add overflow_out.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             sum_bit_out,
  output logic             busy_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow_out,
`endif
  output logic             done_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  // Only WIDTH-1 partial bits are stored; the final bit joins them at completion.
  logic [WIDTH-2:0]   r_sum_sh;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_sh_next;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_sh_next   = {w_fa_sum, r_sum_sh};
  assign sum_bit_out = (r_state == S_SHIFT) & w_fa_sum;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_count      <= '0;
      r_sum_sh     <= '0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_out <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_carry  <= c_in;
            r_count  <= '0;
            busy_out <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_carry  <= w_fa_cout;
          r_count  <= r_count + CNT_W'(1);
          r_sum_sh <= w_sh_next[WIDTH-1:1];
          if (r_count == C_LAST) begin
            sum_out      <= w_sh_next;
            carry_out    <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB xor carry out of the MSB.
            overflow_out <= r_carry ^ w_fa_cout;
`endif
            busy_out     <= 1'b0;
            done_out     <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          done_out <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          busy_out <= 1'b0;
          done_out <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Bench for serial_adder: directed and random additions checked against
// plain integer arithmetic for sum, carry, serial bits and pulse timing.
module tb_serial_adder;

  localparam int W = 8;

  logic         clock    = 1'b0;
  logic         resetn   = 1'b0;
  logic         start_in = 1'b0;
  logic         c_in     = 1'b0;
  logic [W-1:0] a_in     = '0;
  logic [W-1:0] b_in     = '0;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         sum_bit_out;
  logic         busy_out;
  logic         done_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         overflow_out;
  logic         exp_ovf = 1'b0;
`endif

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_sum   = '0;
  logic         exp_carry = 1'b0;

  serial_adder #(.WIDTH(W), .CNT_W(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .c_in         (c_in),
    .sum_out      (sum_out),
    .carry_out    (carry_out),
    .sum_bit_out  (sum_bit_out),
    .busy_out     (busy_out),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow_out (overflow_out),
`endif
    .done_out     (done_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sum"},   sum_out,     exp_sum);
    check({tag, "_carry"}, carry_out,   exp_carry);
    check({tag, "_busy"},  busy_out,    0);
    check({tag, "_done"},  done_out,    0);
    check({tag, "_sbit"},  sum_bit_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"},   overflow_out, exp_ovf);
`endif
  endtask

  // One addition; poke re-asserts start with zero operands mid-operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit poke);
    logic [W:0] full;
    int         s;
    full = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    s    = int'($signed(a)) + int'($signed(b)) + int'(c);
    @(negedge clock);
    a_in = a; b_in = b; c_in = c; start_in = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clock);
      start_in = poke && (k == 2);
      if (poke && (k == 2)) begin
        a_in = '0; b_in = '0; c_in = 1'b0;
      end else begin
        a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
      end
      check("busy",       busy_out,    1);
      check("sbit",       sum_bit_out, full[k]);
      check("done_early", done_out,    0);
      check("hold_sum",   sum_out,     exp_sum);
      check("hold_carry", carry_out,   exp_carry);
    end
    @(negedge clock);
    start_in  = 1'b0;
    exp_sum   = full[W-1:0];
    exp_carry = full[W];
    check("done",      done_out,    1);
    check("busy_done", busy_out,    0);
    check("sum",       sum_out,     exp_sum);
    check("carry",     carry_out,   exp_carry);
    check("sbit_done", sum_bit_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
    check("ovf", overflow_out, exp_ovf);
`else
    if (s == 32'h7fffffff) checks = checks + 0;
`endif
    @(negedge clock);
    check_quiet("after");
  endtask

  initial begin
    int d1, d2, cyc;

    // Reset held for three cycles, then released with start low.
    repeat (3) @(negedge clock);
    check_quiet("in_reset");
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check_quiet("idle");

    run_op(8'h35, 8'h4A, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1);

    // Abort by reset during the fourth shift cycle.
    @(negedge clock);
    a_in = 8'h5A; b_in = 8'h3C; c_in = 1'b1; start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    exp_sum = '0; exp_carry = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf = 1'b0;
`endif
    check_quiet("abort");
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clock);
      check_quiet("post_abort");
    end
    run_op(8'h01, 8'h02, 1'b0, 1'b0);

    // Signed-overflow corner cases (sum/carry checked in every build).
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h35, 8'h4A, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    // Start held high: operations repeat every W+2 cycles.
    @(negedge clock);
    a_in = 8'h21; b_in = 8'h12; c_in = 1'b0; start_in = 1'b1;
    d1 = -1; d2 = -1; cyc = 0;
    while ((d2 < 0) && (cyc < 40)) begin
      @(negedge clock);
      cyc++;
      if (done_out) begin
        if (d1 < 0) d1 = cyc;
        else        d2 = cyc;
      end
    end
    start_in = 1'b0;
    if (d2 < 0) check("period_timeout", 0, 1);
    else        check("period", d2 - d1, W + 2);
    exp_sum = 8'h33; exp_carry = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf = 1'b0;
`endif
    repeat (W + 3) @(negedge clock);
    check_quiet("held_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the existing one-bit full adder, instantiated as the single bit-slice.
- Operands are loaded in parallel and processed LSB-first, one bit per clock, with the carry held in a flip-flop between bits.
- Result is presented in parallel with a one-cycle done pulse.
- Sits directly downstream of the full adder cell. Serves as the area-minimal multi-bit adder for datapath blocks that tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8: operand and sum width in bits, minimum 2.
- CNT_W, 4: bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start_in  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured when start is accepted.
- b_in  input  WIDTH  operand B; captured when start is accepted.
- c_in  input  1  carry-in; captured when start is accepted.
- sum_out  output  WIDTH  last completed sum, registered.
- carry_out  output  1  last completed carry-out, registered.
- sum_bit_out  output  1  current serial sum bit; valid while busy_out=1.
- busy_out  output  1  high while bits are being shifted.
- done_out  output  1  one-cycle pulse when sum_out and carry_out update.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. Port names are clock and resetn.
- Reset values: state=IDLE; sum_out=0, carry_out=0, busy_out=0, done_out=0, sum_bit_out=0; internal operand, carry and count registers all 0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If start_in=1 at a clock edge: a_reg<=a_in, b_reg<=b_in, carry_reg<=c_in, count<=0, go to SHIFT.
  - Otherwise hold.
- SHIFT, every edge:
  - The full adder sees a_reg[0], b_reg[0], carry_reg.
  - Its sum bit shifts into the MSB of sum_sh (right shift).
  - a_reg and b_reg shift right by one; carry_reg<=fa carry; count<=count+1.
  - When count=WIDTH-1 at the edge (last bit): sum_out<={fa_sum, sum_sh[WIDTH-1:1]}, carry_out<=fa carry, go to DONE.
- DONE:
  - done_out=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- busy_out=1 only in SHIFT. sum_bit_out is the combinational fa sum in SHIFT and 0 otherwise.
- Latency: start accepted at edge 0 means WIDTH shifts at edges 1..WIDTH. done_out is high from edge WIDTH to edge WIDTH+1. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start_in in SHIFT or DONE is ignored, with no queuing. start_in held high continuously restarts on each return to IDLE.
- sum_out and carry_out change only on completion and hold indefinitely otherwise. They are not disturbed mid-operation.
- Operands on a_in, b_in and c_in may change freely after the accepting edge.
- Arithmetic is modulo 2**WIDTH on sum_out. carry_out is bit WIDTH of a+b+c_in.
- Reset asserted mid-SHIFT: the operation is aborted immediately and all outputs go to reset values. No done_out is produced.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Adds output overflow_out (1 bit, reset 0), the two's-complement signed overflow.
  - overflow_out = carry_reg XOR fa carry on the last bit. This is the carry into the MSB XOR the carry out of the MSB.
  - Registered alongside sum_out; held until the next completion.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset with resetn=0 for 3 cycles, then release -> sum_out=8'h00, carry_out=0, busy_out=0, done_out=0; FSM stays IDLE with start_in=0.
2. WIDTH=8, a=8'h35, b=8'h4A, c=0, start for 1 cycle -> busy for 8 cycles; done pulse 8 cycles after the accepting edge; sum_out=8'h7F, carry_out=0; sum_bit_out sequence LSB-first 1,1,1,1,1,1,1,0.
3. a=8'hFF, b=8'h01, c=0 -> sum_out=8'h00, carry_out=1. Then a=8'hFF, b=8'hFF, c=1 -> sum_out=8'hFF, carry_out=1.
4. Start with a=8'h10, b=8'h20; pulse start with a=8'h00, b=8'h00 at cycle 3 of SHIFT -> second start ignored; sum_out=8'h30; exactly one done pulse.
5. Start an operation, then drive resetn=0 at cycle 4 of SHIFT -> outputs return to 0 asynchronously, no done pulse. A fresh start with a=8'h01, b=8'h02 then completes normally with sum_out=8'h03.
6. With SERIAL_ADDER_OVF_EN defined: a=8'h7F, b=8'h01 -> sum_out=8'h80, overflow_out=1. a=8'h80, b=8'h80 -> sum_out=8'h00, carry_out=1, overflow_out=1. a=8'h35, b=8'h4A -> overflow_out=0.
